// File: rtl/dna_window_loader.sv
// Serial 2-bit DNA base loader: assembles a search key and a data window, then offers the window downstream.
// Optional LOADER_OVERLAP_EN keeps the last KEY_BASES-1 bases of each full window as the start of the next one.
module dna_window_loader #(
    parameter int DATA_BASES = 512,
    parameter int KEY_BASES  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_base,
    input  logic                    in_key,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_BASES-1:0] data,
    output logic [2*KEY_BASES-1:0]  key,
    output logic [9:0]              window_len,
    output logic                    key_loaded,
    output logic [1:0]              state_dbg
);
    localparam int DW  = $clog2(DATA_BASES + 1);
    localparam int KW  = $clog2(KEY_BASES + 1);
    localparam int OVL = KEY_BASES - 1;
    localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BASES - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_BASES - 1);

    typedef enum logic [1:0] {
        S_KEY  = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2*DATA_BASES-1:0] data_q, data_d;
    logic [2*KEY_BASES-1:0]  key_q, key_d;
    logic [DW-1:0]           data_cnt_q, data_cnt_d;
    logic [KW-1:0]           key_cnt_q, key_cnt_d;
    logic [9:0]              window_len_q, window_len_d;
    logic                    key_loaded_q, key_loaded_d;
    logic                    accept;
    logic [2*DATA_BASES-1:0] data_base;
    logic [2*KEY_BASES-1:0]  key_base;
    logic [2*KEY_BASES-1:0]  key_first;

    // Positions are written once per window/key, so OR-ing a shifted base is an indexed write.
    assign data_base = {in_base, {(2*DATA_BASES-2){1'b0}}} >> {data_cnt_q, 1'b0};
    assign key_base  = {in_base, {(2*KEY_BASES-2){1'b0}}} >> {key_cnt_q, 1'b0};
    assign key_first = {in_base, {(2*KEY_BASES-2){1'b0}}};

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        key_d        = key_q;
        data_cnt_d   = data_cnt_q;
        key_cnt_d    = key_cnt_q;
        window_len_d = window_len_q;
        key_loaded_d = key_loaded_q;
        in_ready     = (state_q != S_HOLD);
        out_valid    = (state_q == S_HOLD);
        accept       = in_valid && in_ready;

        case (state_q)
            S_KEY: begin
                if (accept) begin
                    key_d = key_q | key_base;
                    if (key_cnt_q == KEY_LAST || in_last) begin
                        key_loaded_d = 1'b1;
                        key_cnt_d    = '0;
                        state_d      = S_DATA;
                    end else begin
                        key_cnt_d = key_cnt_q + KW'(1);
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (data_cnt_q == '0 && in_key) begin
                        key_d = key_first;
                        if (in_last) begin
                            key_loaded_d = 1'b1;
                            key_cnt_d    = '0;
                        end else begin
                            key_loaded_d = 1'b0;
                            key_cnt_d    = KW'(1);
                            state_d      = S_KEY;
                        end
                    end else begin
                        data_d     = data_q | data_base;
                        data_cnt_d = data_cnt_q + DW'(1);
                        if (data_cnt_q == DATA_LAST || in_last) begin
                            window_len_d = 10'(data_cnt_q + DW'(1));
                            state_d      = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    data_d     = '0;
                    data_cnt_d = '0;
                    state_d    = S_DATA;
`ifdef LOADER_OVERLAP_EN
                    // A full window hands its tail to the next one so boundary-spanning matches survive.
                    if (window_len_q == 10'(DATA_BASES)) begin
                        data_d     = {data_q[2*OVL-1:0], {(2*(DATA_BASES-OVL)){1'b0}}};
                        data_cnt_d = DW'(OVL);
                    end
`endif
                end
            end
            default: state_d = S_KEY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_KEY;
            data_q       <= '0;
            key_q        <= '0;
            data_cnt_q   <= '0;
            key_cnt_q    <= '0;
            window_len_q <= '0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            key_q        <= key_d;
            data_cnt_q   <= data_cnt_d;
            key_cnt_q    <= key_cnt_d;
            window_len_q <= window_len_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    assign data       = data_q;
    assign key        = key_q;
    assign window_len = window_len_q;
    assign key_loaded = key_loaded_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dna_window_loader.sv
// Directed bench for dna_window_loader: driver tasks push expected windows, a negedge monitor pops and compares.
module tb_dna_window_loader;
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_base = 2'b00;
    logic          in_key = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1023:0] data;
    logic [63:0]   key;
    logic [9:0]    window_len;
    logic          key_loaded;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1023:0] exp_data_q[$];
    logic [63:0]   exp_key_q[$];
    logic [9:0]    exp_len_q[$];
    logic [1023:0] mon_data;
    logic [63:0]   mon_key;
    logic [9:0]    mon_len;

    localparam logic [63:0] K1 = 64'h4EBA3320973BA2B8;
    localparam logic [63:0] K2 = 64'h1B2D3C4E5F607182;

    dna_window_loader #(.DATA_BASES(512), .KEY_BASES(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_key(in_key), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .data(data), .key(key), .window_len(window_len),
        .key_loaded(key_loaded), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clock = ~clock;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            int w;
            w = 0;
            for (int i = 0; i < 32; i++) if (act[32*i +: 32] !== exp[32*i +: 32]) w = i;
            n_fail++;
            $display("FAIL %s: word %0d got %h expected %h", name, w, act[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    function automatic logic [1:0] base_of(input logic [1023:0] v, input int idx);
        return 2'(v >> (1022 - 2*idx));
    endfunction

    task automatic expect_win(input logic [1023:0] d, input logic [63:0] k, input logic [9:0] l);
        exp_data_q.push_back(d);
        exp_key_q.push_back(k);
        exp_len_q.push_back(l);
    endtask

    // driver: called at posedge+1, returns at posedge+1 after the accepting edge
    task automatic send(input logic [1:0] b, input logic k, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_base = b; in_key = k; in_last = l;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end else begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0; in_key = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_data_q.size() != 0 && guard < 20) begin
            @(posedge clock);
            guard++;
        end
        #1;
        check("drain_queue", 1024'(exp_data_q.size()), 1024'(0));
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_window: len=%0d with empty expected queue", window_len);
            end else begin
                mon_data = exp_data_q.pop_front();
                mon_key  = exp_key_q.pop_front();
                mon_len  = exp_len_q.pop_front();
                check("win_data", data, mon_data);
                check("win_key", 1024'(key), 1024'(mon_key));
                check("win_len", 1024'(window_len), 1024'(mon_len));
            end
        end
    end

    initial begin
        logic [1023:0] vec1, vec2, exp_d;
        for (int i = 0; i < 16; i++) vec1[64*i +: 64] = 64'hC3A5_0F96_1E2D_3C4B + 64'(i) * 64'h0101_0101_0101_0101;
        vec1[1023:960] = K1;
        for (int i = 0; i < 16; i++) vec2[64*i +: 64] = 64'h9E37_79B9_7F4A_7C15 ^ (64'(i) * 64'h1111_0000_2222_0003);
        vec2[1023:962] = vec1[61:0];

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 1024'(out_valid), 1024'(0));
        check("rst_in_ready", 1024'(in_ready), 1024'(1));
        check("rst_key_loaded", 1024'(key_loaded), 1024'(0));
        check("rst_data", data, 1024'(0));
        check("rst_key", 1024'(key), 1024'(0));
        check("rst_window_len", 1024'(window_len), 1024'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // full key then full window
        for (int i = 0; i < 32; i++) begin
            send(base_of({K1, 960'b0}, i), 1'b0, 1'b0);
            if (i == 30) check("key_loaded_early", 1024'(key_loaded), 1024'(0));
        end
        check("key_loaded_full", 1024'(key_loaded), 1024'(1));
        check("key_full", 1024'(key), 1024'(K1));
        expect_win(vec1, K1, 10'd512);
        for (int i = 0; i < 512; i++) send(base_of(vec1, i), 1'b0, 1'b0);
        check("full_out_valid", 1024'(out_valid), 1024'(1));
        check("full_in_ready", 1024'(in_ready), 1024'(0));
        wait_drain();

        // second full window, in_last on the 512th base
`ifdef LOADER_OVERLAP_EN
        expect_win(vec2, K1, 10'd512);
        for (int i = 31; i < 512; i++) send(base_of(vec2, i), 1'b0, i == 511);
`else
        expect_win(vec2, K1, 10'd512);
        for (int i = 0; i < 512; i++) send(base_of(vec2, i), 1'b0, i == 511);
`endif
        check("second_out_valid", 1024'(out_valid), 1024'(1));
        wait_drain();

        // reset mid-window
        for (int i = 0; i < 5; i++) send(2'b11, 1'b0, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("midrst_out_valid", 1024'(out_valid), 1024'(0));
        check("midrst_in_ready", 1024'(in_ready), 1024'(1));
        check("midrst_key_loaded", 1024'(key_loaded), 1024'(0));
        check("midrst_data", data, 1024'(0));
        check("midrst_key", 1024'(key), 1024'(0));
        check("midrst_state", 1024'(state_dbg), 1024'(0));
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // short key: 11 00 01 10 with in_last
        send(2'b11, 1'b0, 1'b0);
        send(2'b00, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        check("short_key_pending", 1024'(key_loaded), 1024'(0));
        send(2'b10, 1'b1, 1'b1);
        check("short_key_loaded", 1024'(key_loaded), 1024'(1));
        check("short_key", 1024'(key), 1024'(64'hC600_0000_0000_0000));

        // short window of 3 bases
        exp_d = {2'b01, 2'b11, 2'b10, 1018'b0};
        expect_win(exp_d, 64'hC600_0000_0000_0000, 10'd3);
        send(2'b01, 1'b0, 1'b0);
        send(2'b11, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b1);
        wait_drain();

        // backpressure
        out_ready = 1'b0;
        exp_d = {2'b10, 2'b01, 1020'b0};
        expect_win(exp_d, 64'hC600_0000_0000_0000, 10'd2);
        send(2'b10, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b1);
        in_valid = 1'b1; in_base = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_in_ready", 1024'(in_ready), 1024'(0));
            check("bp_out_valid", 1024'(out_valid), 1024'(1));
            check("bp_data", data, exp_d);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_out_valid", 1024'(out_valid), 1024'(0));
        check("bp_release_in_ready", 1024'(in_ready), 1024'(1));
        check("bp_drained", 1024'(exp_data_q.size()), 1024'(0));
        expect_win({2'b10, 1022'b0}, 64'hC600_0000_0000_0000, 10'd1);
        send(2'b10, 1'b0, 1'b1);
        wait_drain();

        // re-key after a handshake
        send(base_of({K2, 960'b0}, 0), 1'b1, 1'b0);
        check("rekey_state", 1024'(state_dbg), 1024'(0));
        check("rekey_key_loaded", 1024'(key_loaded), 1024'(0));
        check("rekey_key_first", 1024'(key), 1024'({K2[63:62], 62'b0}));
        for (int i = 1; i < 32; i++) send(base_of({K2, 960'b0}, i), 1'b0, 1'b0);
        check("rekey_loaded", 1024'(key_loaded), 1024'(1));
        check("rekey_key", 1024'(key), 1024'(K2));
        expect_win({2'b01, 1022'b0}, K2, 10'd1);
        send(2'b01, 1'b0, 1'b1);
        wait_drain();

        repeat (3) @(posedge clock);
        check("final_queue_empty", 1024'(exp_data_q.size()), 1024'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dna_window_loader.md
# dna_window_loader

- Upstream feeder for `Search_8Comparators`.
- Accepts a serial stream of 2-bit encoded DNA bases and assembles the 64-bit search key and the 1024-bit data window.
- Presents each completed window to the search stage through a valid/ready handshake.
- Handles key reloads, short final windows (zero-padded) and, optionally, overlapping windows so boundary-spanning matches are not lost.

## Interface

Parameters:
- `DATA_BASES`, 512 — bases per window; `data` width is 2*DATA_BASES.
- `KEY_BASES`, 32 — bases per key; `key` width is 2*KEY_BASES.

Ports:
- `clock`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  — `in_base` is valid this cycle.
- `in_ready`  out  1  — loader accepts a base this cycle.
- `in_base`  in  2  — base code: A=00, C=01, G=10, T=11.
- `in_key`  in  1  — in DATA state with empty window, the base starts a new key.
- `in_last`  in  1  — base is the last of the current key or window.
- `out_valid`  out  1  — `data`/`key` hold a complete window.
- `out_ready`  in  1  — search stage consumes the window.
- `data`  out  2*DATA_BASES  — window; first base at [MSB:MSB-1].
- `key`  out  2*KEY_BASES  — key; first base at [MSB:MSB-1].
- `window_len`  out  10  — valid bases in the presented window, 1..512.
- `key_loaded`  out  1  — key register holds a complete key.

## Operation

- Accept = `in_valid && in_ready`.
- States:
  - KEY (reset state).
  - DATA.
  - HOLD.
- Writes are indexed, never shifted: base k goes to bits [MSB-2k : MSB-2k-1]. Unwritten positions stay 00 (zero padding).
- KEY state:
  - Each accept writes `key` at index `key_cnt` and increments `key_cnt`.
  - The key completes when `key_cnt` reaches KEY_BASES, or on an accept with `in_last=1`.
  - On completion: `key_loaded`=1, `key_cnt`=0, go to DATA. `in_key` is ignored in KEY.
- DATA state:
  - An accept with `data_cnt==0 && in_key==1` re-keys: clear `key`, write the base at key index 0, `key_cnt`=1, `key_loaded`=0, go to KEY. If `in_last` is also set, the key completes immediately with one base and the state stays DATA.
  - Otherwise the accept writes `data` at index `data_cnt` and increments `data_cnt`.
  - When `data_cnt` reaches DATA_BASES, or on an accept with `in_last=1`: `window_len` = bases written, go to HOLD.
- HOLD state:
  - `in_ready`=0 and `out_valid`=1; `data`, `key` and `window_len` are stable.
  - On `out_valid && out_ready`: clear `data`, `data_cnt`=0, go to DATA.
- `in_ready` = (state != HOLD).
- Reset values:
  - State KEY, so `in_ready`=1.
  - `out_valid`=0.
  - `data`, `key` = all zeros.
  - `window_len`=0.
  - `key_loaded`=0.
  - All counters 0.
- Reset mid-window discards all partial key and data content.

## Timing

- `out_valid` is registered and rises the cycle after the accept that completes the window (the 512th base, or the `in_last` base).
- The handshake cycle drops `out_valid`; `in_ready` returns to 1 the next cycle. There is no bypass, so each window costs DATA_BASES accepts plus at least 1 HOLD cycle.
- `key_loaded` rises the cycle after the completing key accept.
- Inputs are sampled only on accept cycles; `in_key` and `in_last` are ignored when `in_valid`=0.
- `in_last` on the 512th base is identical to a normal full window (`window_len`=512).
- `out_ready` held high in HOLD completes the handshake in the first HOLD cycle.

## Configuration

- `LOADER_OVERLAP_EN` defined:
  - On the handshake of a full window (`window_len`==DATA_BASES), keep the last KEY_BASES-1 bases.
  - New `data` = {old `data`[2*(KEY_BASES-1)-1:0], zeros}, with `data_cnt`=KEY_BASES-1.
  - Subsequent windows therefore overlap by 31 bases.
  - Short windows (`in_last`) still clear fully.
- `LOADER_OVERLAP_EN` undefined: every handshake clears `data`, and windows are disjoint.

## Test plan

- **Reset:** hold `reset`=0 mid-stream → `out_valid`=0, `key_loaded`=0, `data`=0, `key`=0, `in_ready`=1 immediately.
- **Full load:** load 32 key bases, then stream 512 bases matching the search bench vector (key = top 64 bits of data) → `out_valid`=1 one cycle after the last base, `data` equals that 1024-bit vector, `key`=64'h4EBA3320973BA2B8, `window_len`=512.
- **Short key and window:**
  - 4 key bases ending with `in_last` → `key`[63:56] set, `key`[55:0]=0.
  - Data stream of 3 bases with `in_last` on the 3rd → `window_len`=3, `data`[1017:0]=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with `in_valid`=1 → `in_ready`=0 and no data change throughout; set `out_ready`=1 → `in_ready`=1 the next cycle, and the first new base lands at `data`[1023:1022].
- **Re-key:** after a handshake, send `in_key`=1 on the first base → state KEY, `key_loaded`=0; after 32 bases `key_loaded`=1 and the new key is present.
- **Overlap** (`LOADER_OVERLAP_EN`): two consecutive full windows → 2nd window `data`[1023:962] equals 1st window `data`[61:0], and only 481 further accepts are needed to present it.
